imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
- Boot/reload sequencer for the 64-word instruction memory of the single-cycle RISC-V core.
- Accepts a word stream over a valid/ready port and writes it sequentially from word 0.
- Holds the CPU stalled while loading, then releases it and hands the imem address port to the CPU PC.
- Sits between the core's fetch path, the loader link (UART/debug bridge) and the imem write port.

Parameters:
- DEPTH, 64, number of 32-bit imem words.
- AW, 6, word-address width; must satisfy 2**AW == DEPTH.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load.
- length  in  AW+1  number of words to load; sampled when start is accepted.
- s_valid  in  1  loader word valid.
- s_data  in  32  loader word.
- s_ready  out  1  controller accepts s_data this cycle.
- cpu_pc  in  32  CPU fetch byte address.
- cpu_stall  out  1  freezes the CPU PC and register writes.
- imem_addr  out  32  byte address to imem read port.
- imem_we  out  1  imem write enable.
- imem_waddr  out  AW  imem word write address.
- imem_wdata  out  32  imem write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes successfully.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- States: WAIT, LOAD, FIN, RUN. Reset enters WAIT.
- Reset values: cnt=0, s_ready=0, cpu_stall=1, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, err=0, imem_addr=0.
- WAIT:
  - cpu_stall=1; imem_addr=0.
  - start with 1<=length<=DEPTH: latch length, clear cnt and err, go to LOAD.
  - start with length==0 or length>DEPTH: set err, remain in the current state (WAIT or RUN).
- LOAD:
  - busy=1, s_ready=1, cpu_stall=1.
  - A transfer (s_valid && s_ready) drives imem_we=1, imem_waddr=cnt, imem_wdata=s_data combinationally in that cycle; cnt increments on the edge.
  - The transfer with cnt==length-1 goes to FIN; s_ready=0 from the next cycle.
  - s_valid low: hold, no write, no timeout.
  - start is ignored in LOAD.
- FIN:
  - One cycle: done=1, busy=0, cpu_stall=1, s_ready=0; go to RUN.
- RUN:
  - cpu_stall=0; imem_addr=cpu_pc (mux, zero latency).
  - start with a legal length goes to LOAD: cpu_stall=1 from the next cycle, cnt=0.
- imem_addr during WAIT/LOAD/FIN = {imem_waddr, 2'b00}.
- Words beyond length are not written; unwritten imem contents are untouched.
- Reset asserted mid-LOAD: return to WAIT immediately; partially written words remain in imem; cpu_stall=1.
- Address wrap: cnt is AW+1 bits; length<=DEPTH guarantees imem_waddr never wraps.

Optional Feature:
- Macro: IMEM_BOOT_CSUM_EN.
- With the macro defined:
  - After the last data word, LOAD accepts one extra word, the expected checksum (s_ready stays 1; no imem write).
  - A 32-bit wrap-around sum of all data words is accumulated.
  - Match: FIN then RUN as normal.
  - Mismatch: set err, no done pulse, go to WAIT (CPU stays stalled).
- Without the macro: no checksum word is consumed and no accumulator logic exists.

Test Plan:
- Reset, no start -> cpu_stall=1, s_ready=0, err=0 indefinitely; imem_we never asserts.
- start, length=3, words 0x00500113, 0x00C00193, 0xFF718393 back-to-back -> imem_we on 3 consecutive cycles at waddr 0,1,2; done pulses one cycle later; cpu_stall=0 the cycle after; imem_addr follows cpu_pc=0x8 -> 0x8.
- Same load with s_valid toggling every other cycle -> exactly 3 writes, waddr 0,1,2; no duplicate writes; done once.
- start with length=0, then with length=65 -> err=1, state unchanged, no writes; a following legal start clears err.
- In RUN, start with length=64 -> cpu_stall=1 the next cycle; 64 writes covering waddr 0..63; then RUN. rst_n pulsed low mid-load at word 10 -> WAIT, cpu_stall=1, s_ready=0 immediately.
- IMEM_BOOT_CSUM_EN: length=2, words 1 and 2 with checksum 3 -> done, RUN; checksum 4 -> err=1, no done, WAIT with cpu_stall=1.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Boot/reload sequencer: streams words into the 64-word imem, stalls the CPU while loading.
// Optional trailing-checksum verification of the loaded image when IMEM_BOOT_CSUM_EN is defined.
module imem_boot_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   length,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    input  logic [31:0]   cpu_pc,
    output logic          cpu_stall,
    output logic [31:0]   imem_addr,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_LOAD,
        ST_FIN,
        ST_RUN
    } state_t;

    state_t      state, state_nx;
    logic [AW:0] cnt, cnt_nx;
    logic [AW:0] len_q, len_nx;
    logic        err_nx;
    logic        xfer;
    logic        len_ok;

`ifdef IMEM_BOOT_CSUM_EN
    logic [31:0] sum, sum_nx;
    logic        csum_phase;

    // Once every data word has been counted, the next transfer is the checksum.
    assign csum_phase = (cnt == len_q);
`else
    logic        last_data;

    assign last_data = ((cnt + 1'b1) == len_q);
`endif

    assign len_ok = (length != '0) && (length <= MAX_LEN);
    assign xfer   = s_valid && s_ready;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        len_nx     = len_q;
        err_nx     = err;
`ifdef IMEM_BOOT_CSUM_EN
        sum_nx     = sum;
`endif
        s_ready    = 1'b0;
        cpu_stall  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        imem_addr  = '0;

        case (state)
            ST_WAIT, ST_RUN: begin
                if (state == ST_RUN) begin
                    cpu_stall = 1'b0;
                    imem_addr = cpu_pc;
                end
                if (start) begin
                    if (len_ok) begin
                        state_nx = ST_LOAD;
                        len_nx   = length;
                        cnt_nx   = '0;
                        err_nx   = 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
                        sum_nx   = '0;
`endif
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                busy       = 1'b1;
                s_ready    = 1'b1;
                imem_waddr = cnt[AW-1:0];
                imem_addr  = {{(30-AW){1'b0}}, cnt[AW-1:0], 2'b00};
                if (xfer) begin
`ifdef IMEM_BOOT_CSUM_EN
                    if (csum_phase) begin
                        if (s_data == sum) begin
                            state_nx = ST_FIN;
                        end else begin
                            err_nx   = 1'b1;
                            state_nx = ST_WAIT;
                        end
                    end else begin
                        imem_we    = 1'b1;
                        imem_wdata = s_data;
                        cnt_nx     = cnt + 1'b1;
                        sum_nx     = sum + s_data;
                    end
`else
                    imem_we    = 1'b1;
                    imem_wdata = s_data;
                    cnt_nx     = cnt + 1'b1;
                    if (last_data) begin
                        state_nx = ST_FIN;
                    end
`endif
                end
            end

            ST_FIN: begin
                done     = 1'b1;
                state_nx = ST_RUN;
            end

            default: begin
                state_nx = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
            cnt   <= '0;
            len_q <= '0;
            err   <= 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
            sum   <= '0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            len_q <= len_nx;
            err   <= err_nx;
`ifdef IMEM_BOOT_CSUM_EN
            sum   <= sum_nx;
`endif
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: driver queues expected writes/done pulses, a monitor pops them.
// Exercises the checksum path too when IMEM_BOOT_CSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_boot_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic [AW:0]   length  = '0;
    logic          s_valid = 1'b0;
    logic [31:0]   s_data  = '0;
    logic [31:0]   cpu_pc  = '0;
    logic          s_ready;
    logic          cpu_stall;
    logic [31:0]   imem_addr;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .length     (length),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .cpu_pc     (cpu_pc),
        .cpu_stall  (cpu_stall),
        .imem_addr  (imem_addr),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_wq[$];
    int          done_exp  = 0;
    int          done_seen = 0;
    logic [31:0] model_mem [DEPTH] = '{default: 32'hDEADBEEF};
    logic [31:0] seen_mem  [DEPTH] = '{default: 32'hDEADBEEF};
    logic [31:0] wq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, when inputs and combinational outputs are settled.
    int cyc = 0;
    int last_xfer = -10;
    always @(negedge clk) begin : monitor
        wr_t e;
        cyc++;
        if (rst_n) begin
            if (s_valid && s_ready) last_xfer = cyc;
            if (imem_we) begin
                if (exp_wq.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_wq.pop_front();
                    check("waddr", 32'(imem_waddr), 32'(e.addr));
                    check("wdata", imem_wdata, e.data);
                    check("write_byte_addr", imem_addr, 32'(e.addr) << 2);
                    check("write_stall", 32'(cpu_stall), 32'd1);
                    seen_mem[imem_waddr] = imem_wdata;
                end
            end
            if (done) begin
                done_seen++;
                if (done_seen > done_exp) check("unexpected_done", 32'd1, 32'd0);
                else check("done_latency", 32'(cyc - last_xfer), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input bit is_data, input bit gap);
        if (gap) tick();
        s_valid = 1'b1;
        s_data  = w;
        if (is_data) exp_wq.push_back(wr_t'{addr: AW'(idx), data: w});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_ready) begin
                if (is_data) model_mem[idx] = w;
                tick();
                s_valid = 1'b0;
                return;
            end
        end
        check("handshake_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle before every word, 2 random idles.
    task automatic do_load(input logic [31:0] words[$], input int gap_mode, input bit csum_good);
        int          n;
        logic [31:0] sum;
        bit          gap;
        n   = words.size();
        sum = '0;
        do_start((AW+1)'(n));
        check("busy_after_start", 32'(busy), 32'd1);
        check("stall_after_start", 32'(cpu_stall), 32'd1);
        check("err_cleared", 32'(err), 32'd0);
        if (csum_good) done_exp++;
        for (int i = 0; i < n; i++) begin
            gap = (gap_mode == 1) || ((gap_mode == 2) && ($urandom_range(0, 1) == 1));
            send_word(i, words[i], 1'b1, gap);
            sum += words[i];
        end
`ifdef IMEM_BOOT_CSUM_EN
        gap = (gap_mode == 1) || ((gap_mode == 2) && ($urandom_range(0, 1) == 1));
        send_word(0, csum_good ? sum : sum + 32'd1, 1'b0, gap);
        if (!csum_good) begin
            check("csum_err", 32'(err), 32'd1);
            check("csum_busy", 32'(busy), 32'd0);
            check("csum_ready", 32'(s_ready), 32'd0);
            tick();
            check("csum_stays_stalled", 32'(cpu_stall), 32'd1);
            check("csum_wait_addr", imem_addr, 32'd0);
            return;
        end
`endif
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_stall", 32'(cpu_stall), 32'd1);
        check("fin_ready", 32'(s_ready), 32'd0);
        tick();
        check("run_stall", 32'(cpu_stall), 32'd0);
        check("run_err", 32'(err), 32'd0);
        cpu_pc = 32'h8;
        #1;
        check("run_addr_8", imem_addr, 32'h8);
        cpu_pc = {$urandom_range(0, 255), 2'b00};
        #1;
        check("run_addr_rand", imem_addr, cpu_pc);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          mism;
        int          len;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("idle_stall", 32'(cpu_stall), 32'd1);
        check("idle_ready", 32'(s_ready), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_addr", imem_addr, 32'd0);

        do_start(7'd0);
        check("len0_err", 32'(err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        do_start(7'd65);
        check("len65_err", 32'(err), 32'd1);
        check("len65_stall", 32'(cpu_stall), 32'd1);
        check("len65_ready", 32'(s_ready), 32'd0);

        wq = {};
        wq.push_back(32'h00500113);
        wq.push_back(32'h00C00193);
        wq.push_back(32'hFF718393);
        do_load(wq, 0, 1'b1);
        do_load(wq, 1, 1'b1);

        do_start(7'd0);
        check("run_illegal_err", 32'(err), 32'd1);
        check("run_illegal_stays_run", 32'(cpu_stall), 32'd0);

        wq = {};
        for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
        do_load(wq, 2, 1'b1);

        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, DEPTH);
            wq  = {};
            for (int i = 0; i < len; i++) wq.push_back($urandom);
            do_load(wq, 2, 1'b1);
        end

        // Reset in the middle of a full-depth load, after word 10.
        do_start(7'd64);
        check("reload_stall", 32'(cpu_stall), 32'd1);
        for (int i = 0; i < 10; i++) send_word(i, $urandom, 1'b1, $urandom_range(0, 1) == 1);
        rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(cpu_stall), 32'd1);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_stall", 32'(cpu_stall), 32'd1);
        check("post_rst_addr", imem_addr, 32'd0);
        check("post_rst_err", 32'(err), 32'd0);

`ifdef IMEM_BOOT_CSUM_EN
        wq = {};
        wq.push_back(32'd1);
        wq.push_back(32'd2);
        do_load(wq, 0, 1'b1);
        do_load(wq, 0, 1'b0);
`endif

        for (int i = 0; i < 4; i++) tick();
        check("writes_pending", 32'(exp_wq.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(done_exp));
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (seen_mem[i] !== model_mem[i]) mism++;
        check("mem_image", 32'(mism), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
